// File: rtl/neural_trainer_if.sv
// Sample/result handshake bundle for neural_trainer: sample channel in, prediction channel out.
// Current weights ride along with the result.
interface neural_trainer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        t;
    logic        train;
    logic        out_valid;
    logic        out_ready;
    logic        f;
    logic        err;
    logic [15:0] ca;
    logic [15:0] cb;

    modport slave (
        input  in_valid, a, b, t, train, out_ready,
        output in_ready, out_valid, f, err, ca, cb
    );

    modport master (
        output in_valid, a, b, t, train, out_ready,
        input  in_ready, out_valid, f, err, ca, cb
    );
endinterface

// File: rtl/neural_trainer.sv
// Two-input perceptron with online learning in Q8.8.
// One shared 16x16 multiplier evaluates A*CA then B*CB; the weights update with saturation on error.
module neural_trainer #(
    parameter int          SHIFT   = 4,
    parameter logic [15:0] INIT_CA = 16'h0100,
    parameter logic [15:0] INIT_CB = 16'h0100
) (
    input  logic              clk,
    input  logic              rst,
    neural_trainer_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, MUL_A, MUL_B, DECIDE, RESP} state_t;

    state_t             state_reg, state_next;
    logic [1:0][15:0]   x_reg, x_next;      // [0] = A, [1] = B
    logic [1:0][15:0]   w_reg, w_next;      // [0] = CA, [1] = CB
    logic [1:0][15:0]   w_upd;
    logic               t_reg, t_next;
    logic               train_reg, train_next;
    logic [32:0]        acc_reg, acc_next;
    logic               f_reg, f_next;
    logic               err_reg, err_next;

    logic               mul_sel;
    logic signed [15:0] mul_x, mul_w;
    logic signed [31:0] prod;

    // Operand mux in front of the single multiplier: lane 0 in MUL_A, lane 1 in MUL_B.
    assign mul_sel = (state_reg == MUL_B);
    assign mul_x   = mul_sel ? x_reg[1] : x_reg[0];
    assign mul_w   = mul_sel ? w_reg[1] : w_reg[0];
    assign prod    = mul_x * mul_w;

    // Candidate weight per lane; the sign of the step follows the target, since ERR fixes the direction.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [15:0] delta;
            logic signed [16:0] wide_w;
            logic signed [16:0] wide_d;
            logic signed [16:0] sum;

            assign delta  = $signed(x_reg[gi]) >>> SHIFT;
            assign wide_w = {w_reg[gi][15], w_reg[gi]};
            assign wide_d = {delta[15], delta};
            assign sum    = t_reg ? (wide_w + wide_d) : (wide_w - wide_d);
            assign w_upd[gi] = (sum[16] != sum[15]) ? (sum[16] ? 16'h8000 : 16'h7FFF)
                                                    : sum[15:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            w_reg     <= {INIT_CB, INIT_CA};
            t_reg     <= 1'b0;
            train_reg <= 1'b0;
            acc_reg   <= '0;
            f_reg     <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            w_reg     <= w_next;
            t_reg     <= t_next;
            train_reg <= train_next;
            acc_reg   <= acc_next;
            f_reg     <= f_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        w_next     = w_reg;
        t_next     = t_reg;
        train_next = train_reg;
        acc_next   = acc_reg;
        f_next     = f_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    x_next     = {bus.b, bus.a};
                    t_next     = bus.t;
                    train_next = bus.train;
                    state_next = MUL_A;
                end
            end
            MUL_A: begin
                acc_next   = {prod[31], prod};
                state_next = MUL_B;
            end
            MUL_B: begin
                // Two sign-extended 32-bit products cannot overflow 33 bits.
                acc_next   = acc_reg + {prod[31], prod};
                state_next = DECIDE;
            end
            DECIDE: begin
                f_next   = ~acc_reg[32];
                err_next = f_next ^ t_reg;
                if (train_reg && err_next) begin
                    w_next = w_upd;
                end
                state_next = RESP;
            end
            RESP: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == RESP);
    assign bus.f         = f_reg;
    assign bus.err       = err_reg;
    assign bus.ca        = w_reg[0];
    assign bus.cb        = w_reg[1];

endmodule

// File: tb/tb_neural_trainer.sv
// Directed bench for neural_trainer: three instances with different initial weights share one stimulus;
// each scenario resets and then checks the instance it targets.
module tb_neural_trainer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   sel      = 0;
    int   lat;

    always #5 clk = ~clk;

    neural_trainer_if ifc0 ();
    neural_trainer_if ifc1 ();
    neural_trainer_if ifc2 ();

    neural_trainer #(.SHIFT(4), .INIT_CA(16'h0100), .INIT_CB(16'h0100))
        dut0 (.clk(clk), .rst(rst), .bus(ifc0));
    neural_trainer #(.SHIFT(4), .INIT_CA(16'h0100), .INIT_CB(16'hFF00))
        dut1 (.clk(clk), .rst(rst), .bus(ifc1));
    neural_trainer #(.SHIFT(4), .INIT_CA(16'h7FF0), .INIT_CB(16'h8000))
        dut2 (.clk(clk), .rst(rst), .bus(ifc2));

    logic        in_ready_o [3];
    logic        out_valid_o[3];
    logic        f_o        [3];
    logic        err_o      [3];
    logic [15:0] ca_o       [3];
    logic [15:0] cb_o       [3];

    assign in_ready_o[0] = ifc0.in_ready;  assign in_ready_o[1] = ifc1.in_ready;  assign in_ready_o[2] = ifc2.in_ready;
    assign out_valid_o[0] = ifc0.out_valid; assign out_valid_o[1] = ifc1.out_valid; assign out_valid_o[2] = ifc2.out_valid;
    assign f_o[0] = ifc0.f;   assign f_o[1] = ifc1.f;   assign f_o[2] = ifc2.f;
    assign err_o[0] = ifc0.err; assign err_o[1] = ifc1.err; assign err_o[2] = ifc2.err;
    assign ca_o[0] = ifc0.ca; assign ca_o[1] = ifc1.ca; assign ca_o[2] = ifc2.ca;
    assign cb_o[0] = ifc0.cb; assign cb_o[1] = ifc1.cb; assign cb_o[2] = ifc2.cb;

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [15:0] av, input logic [15:0] bv,
                          input logic tv, input logic trv);
        ifc0.in_valid = v; ifc1.in_valid = v; ifc2.in_valid = v;
        ifc0.a = av;       ifc1.a = av;       ifc2.a = av;
        ifc0.b = bv;       ifc1.b = bv;       ifc2.b = bv;
        ifc0.t = tv;       ifc1.t = tv;       ifc2.t = tv;
        ifc0.train = trv;  ifc1.train = trv;  ifc2.train = trv;
    endtask

    task automatic set_ready(input logic r);
        ifc0.out_ready = r; ifc1.out_ready = r; ifc2.out_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) wait_edge();
        rst = 1'b0;
    endtask

    // Offer one sample and count edges from acceptance until OUT_VALID (bounded).
    task automatic run_sample(input logic [15:0] av, input logic [15:0] bv,
                              input logic tv, input logic trv, output int edges);
        set_in(1'b1, av, bv, tv, trv);
        wait_edge();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        edges = 0;
        while (!out_valid_o[sel] && edges < 10) begin
            wait_edge();
            edges++;
        end
    endtask

    task automatic expect_result(input string name, input logic ef, input logic ee,
                                 input logic [15:0] eca, input logic [15:0] ecb);
        check({name, " latency"}, 33'(lat), 33'd3);
        check({name, " f"},   f_o[sel],   ef);
        check({name, " err"}, err_o[sel], ee);
        check({name, " ca"},  ca_o[sel],  eca);
        check({name, " cb"},  cb_o[sel],  ecb);
    endtask

    task automatic finish_handshake(input string name);
        set_ready(1'b1);
        wait_edge();
        set_ready(1'b0);
        check({name, " in_ready after handshake"}, in_ready_o[sel], 1'b1);
        check({name, " out_valid after handshake"}, out_valid_o[sel], 1'b0);
    endtask

    initial begin
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        set_ready(1'b0);

        // Reset state
        sel = 0;
        do_reset();
        check("reset ca", ca_o[0], 16'h0100);
        check("reset cb", cb_o[0], 16'h0100);
        check("reset in_ready", in_ready_o[0], 1'b1);
        check("reset out_valid", out_valid_o[0], 1'b0);
        check("reset f", f_o[0], 1'b0);
        check("reset err", err_o[0], 1'b0);

        // Correct prediction: 1*1 + 1*1 > 0
        run_sample(16'h0100, 16'h0100, 1'b1, 1'b1, lat);
        expect_result("correct", 1'b1, 1'b0, 16'h0100, 16'h0100);
        finish_handshake("correct");

        // Boundary: 1*1 + 1*(-1) == 0 gives F=1
        do_reset();
        sel = 1;
        run_sample(16'h0100, 16'h0100, 1'b1, 1'b1, lat);
        expect_result("boundary", 1'b1, 1'b0, 16'h0100, 16'hFF00);
        finish_handshake("boundary");

        // Learning, positive step: CA += FF00>>>4 = FFF0
        do_reset();
        sel = 0;
        run_sample(16'hFF00, 16'hFF00, 1'b1, 1'b1, lat);
        expect_result("learn_pos", 1'b0, 1'b1, 16'h00F0, 16'h00F0);
        finish_handshake("learn_pos");

        // Same sample with TRAIN=0: weights untouched
        do_reset();
        run_sample(16'hFF00, 16'hFF00, 1'b1, 1'b0, lat);
        expect_result("infer_only", 1'b0, 1'b1, 16'h0100, 16'h0100);
        finish_handshake("infer_only");

        // Learning, negative step: F=1, T=0, CA -= 0010
        do_reset();
        run_sample(16'h0100, 16'h0100, 1'b0, 1'b1, lat);
        expect_result("learn_neg", 1'b1, 1'b1, 16'h00F0, 16'h00F0);
        finish_handshake("learn_neg");

        // Saturation: 7FF0+0010 clamps to 7FFF, 8000+0010 = 8010
        do_reset();
        sel = 2;
        run_sample(16'h0100, 16'h0100, 1'b1, 1'b1, lat);
        expect_result("saturate", 1'b0, 1'b1, 16'h7FFF, 16'h8010);
        finish_handshake("saturate");

        // Backpressure with a new sample pending
        do_reset();
        sel = 0;
        run_sample(16'h0100, 16'h0100, 1'b1, 1'b1, lat);
        expect_result("bp_first", 1'b1, 1'b0, 16'h0100, 16'h0100);
        set_in(1'b1, 16'hFF00, 16'hFF00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_edge();
            check($sformatf("bp hold%0d out_valid", i), out_valid_o[0], 1'b1);
            check($sformatf("bp hold%0d in_ready", i), in_ready_o[0], 1'b0);
            check($sformatf("bp hold%0d f/err/ca/cb", i),
                  {f_o[0], err_o[0], ca_o[0], cb_o[0]}, {1'b1, 1'b0, 16'h0100, 16'h0100});
        end
        set_ready(1'b1);
        wait_edge();
        set_ready(1'b0);
        check("bp release in_ready", in_ready_o[0], 1'b1);
        check("bp release out_valid", out_valid_o[0], 1'b0);
        // Pending sample (-1,-1), T=0: sum < 0 so F=0, no error
        run_sample(16'hFF00, 16'hFF00, 1'b0, 1'b1, lat);
        expect_result("bp_second", 1'b0, 1'b0, 16'h0100, 16'h0100);
        finish_handshake("bp_second");

        // Reset while in MUL_B during a learning sample
        do_reset();
        set_in(1'b1, 16'hFF00, 16'hFF00, 1'b1, 1'b1);
        wait_edge();
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        wait_edge();
        rst = 1'b1;
        wait_edge();
        rst = 1'b0;
        check("midrst in_ready", in_ready_o[0], 1'b1);
        check("midrst out_valid", out_valid_o[0], 1'b0);
        check("midrst ca", ca_o[0], 16'h0100);
        check("midrst cb", cb_o[0], 16'h0100);
        begin
            logic seen_valid;
            seen_valid = 1'b0;
            repeat (5) begin
                wait_edge();
                if (out_valid_o[0]) seen_valid = 1'b1;
            end
            check("midrst no late out_valid", seen_valid, 1'b0);
            check("midrst weights stay", {ca_o[0], cb_o[0]}, {16'h0100, 16'h0100});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
